// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional grant statistics are enabled with `DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// Requester and memory-side signals of the data-memory arbiter.
// Handshake: req/we/addr/wdata are held until a one-cycle gnt pulse; a read is answered by a one-cycle rvalid pulse with rdata.
interface dmem_arb_if #(
  parameter int A_BITS = 10,
  parameter int D_BITS = 32
) ();
  logic              req0, req1;
  logic              we0, we1;
  logic [A_BITS-1:0] addr0, addr1;
  logic [D_BITS-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [D_BITS-1:0] rdata;
  logic              read, write;
  logic [A_BITS-1:0] address;
  logic [D_BITS-1:0] data_out;
  logic [D_BITS-1:0] data_in;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, data_in,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, read, write, address, data_out
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, data_in,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, read, write, address, data_out
  );
endinterface

// File: rtl/dmem_arb_rr.sv
// Two-way round-robin picker; remembers the last granted port and favours the other on contention.
module dmem_arb_rr
  import dmem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic any,
  output logic win
);
  logic last;

  always_comb begin
    any = req0 | req1;
    if (req0 && req1) win = ~last;
    else              win = req1;
  end

  // Reset state makes port 1 the first preferred winner.
  always_ff @(posedge clk) begin
    if (rst)              last <= PORT_CORE;
    else if (take && any) last <= win;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: round-robin between core (port 0) and DMA (port 1),
// one access in flight, fixed-latency reads. `DMEM_ARB_STATS_EN adds per-port grant counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int A_BITS = 10,
  parameter int D_BITS = 32,
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  dmem_arb_if.slave  bus,
  output state_t     state_dbg
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] gcnt0,
  output logic [CNT_W-1:0] gcnt1
`endif
);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              cur;
  logic              gnt0_r, gnt1_r, rvalid0_r, rvalid1_r, read_r, write_r;
  logic [A_BITS-1:0] address_r;
  logic [D_BITS-1:0] data_out_r, rdata_r;

  logic              any, win;
  logic              sel_we;
  logic [A_BITS-1:0] sel_addr;
  logic [D_BITS-1:0] sel_wdata;

  dmem_arb_rr u_rr (
    .clk  (clk),
    .rst  (rst),
    .req0 (bus.req0),
    .req1 (bus.req1),
    .take (state == IDLE),
    .any  (any),
    .win  (win)
  );

  always_comb begin
    sel_we    = win ? bus.we1    : bus.we0;
    sel_addr  = win ? bus.addr1  : bus.addr0;
    sel_wdata = win ? bus.wdata1 : bus.wdata0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cur        <= PORT_CORE;
      gnt0_r     <= 1'b0;
      gnt1_r     <= 1'b0;
      rvalid0_r  <= 1'b0;
      rvalid1_r  <= 1'b0;
      read_r     <= 1'b0;
      write_r    <= 1'b0;
      address_r  <= '0;
      data_out_r <= '0;
      rdata_r    <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          state      <= ISSUE;
          cur        <= win;
          gnt0_r     <= ~win;
          gnt1_r     <= win;
          read_r     <= ~sel_we;
          write_r    <= sel_we;
          address_r  <= sel_addr;
          data_out_r <= sel_wdata;
        end
        ISSUE: begin
          gnt0_r  <= 1'b0;
          gnt1_r  <= 1'b0;
          read_r  <= 1'b0;
          write_r <= 1'b0;
          if (write_r) state <= IDLE;
          else begin
            state <= WAIT;
            cnt   <= CW'(RD_LAT - 1);
          end
        end
        // Counter is preloaded so data_in is sampled RD_LAT cycles after the strobe.
        WAIT: begin
          if (cnt == '0) begin
            rdata_r   <= bus.data_in;
            rvalid0_r <= ~cur;
            rvalid1_r <= cur;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          rvalid0_r <= 1'b0;
          rvalid1_r <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt0 <= '0;
      gcnt1 <= '0;
    end else if (state == ISSUE) begin
      if (gnt0_r) gcnt0 <= sat_inc(gcnt0);
      if (gnt1_r) gcnt1 <= sat_inc(gcnt1);
    end
  end
`endif

  assign bus.gnt0     = gnt0_r;
  assign bus.gnt1     = gnt1_r;
  assign bus.rvalid0  = rvalid0_r;
  assign bus.rvalid1  = rvalid1_r;
  assign bus.read     = read_r;
  assign bus.write    = write_r;
  assign bus.address  = address_r;
  assign bus.data_out = data_out_r;
  assign bus.rdata    = rdata_r;
  assign state_dbg    = state;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (RD_LAT=1); grant counters checked when
// DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AB = 10;
  localparam int DB = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arb_if #(.A_BITS(AB), .D_BITS(DB)) bus ();
  state_t state_dbg;
`ifdef DMEM_ARB_STATS_EN
  logic [CNT_W-1:0] gcnt0, gcnt1;
`endif

  dmem_arbiter #(.A_BITS(AB), .D_BITS(DB), .RD_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
`ifdef DMEM_ARB_STATS_EN
    ,
    .gcnt0     (gcnt0),
    .gcnt1     (gcnt1)
`endif
  );

  // memory model: contents are a fixed function of the address, one-cycle read latency
  function automatic logic [DB-1:0] mem_val(input logic [AB-1:0] a);
    case (a)
      10'd9:   return 32'h0000_1234;
      10'd12:  return 32'hCAFE_0012;
      default: return 32'h5A00_0000 | {22'h0, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.read) bus.data_in <= mem_val(bus.address);
  end

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [DB-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DB-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic chk_quiet(input string tag);
    chk(tag, {26'b0, bus.gnt0, bus.gnt1, bus.read, bus.write, bus.rvalid0, bus.rvalid1}, 32'h0);
  endtask

  // driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int rv_seen;

  initial begin
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;

    // reset state
    rst = 1'b1;
    tick(); tick();
    chk_quiet("rst_strobes");
    chk("rst_address", 32'(bus.address), 32'h0);
    chk("rst_data_out", bus.data_out, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b0;

    // single write from port 0
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 10'd5; bus.wdata0 = 32'hA5A5;
    tick();
    chk("t1_gnt0", 32'(bus.gnt0), 32'h1);
    chk("t1_gnt1", 32'(bus.gnt1), 32'h0);
    chk("t1_write", 32'(bus.write), 32'h1);
    chk("t1_read", 32'(bus.read), 32'h0);
    chk("t1_address", 32'(bus.address), 32'd5);
    chk("t1_data_out", bus.data_out, 32'hA5A5);
    chk("t1_state", 32'(state_dbg), 32'(ISSUE));
    bus.req0 = 0;
    tick();
    chk_quiet("t1_after");
    chk("t1_idle", 32'(state_dbg), 32'(IDLE));

    // single read from port 1
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 10'd9;
    tick();
    chk("t2_gnt1", 32'(bus.gnt1), 32'h1);
    chk("t2_read", 32'(bus.read), 32'h1);
    chk("t2_address", 32'(bus.address), 32'd9);
    exp_q.push_back(32'h0000_1234);
    bus.req1 = 0;
    tick();
    chk("t2_wait", 32'(state_dbg), 32'(WAIT));
    chk_quiet("t2_wait_quiet");
    tick();
    chk("t2_rvalid1", 32'(bus.rvalid1), 32'h1);
    chk("t2_rvalid0", 32'(bus.rvalid0), 32'h0);
    chk("t2_rdata", bus.rdata, pop_exp());
    tick();
    chk("t2_rvalid_drop", 32'(bus.rvalid1), 32'h0);
    chk("t2_rdata_hold", bus.rdata, 32'h0000_1234);
    chk("t2_idle", 32'(state_dbg), 32'(IDLE));

    // busy hold-off: port 0 asks while a port-1 read is in WAIT
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 10'd12;
    tick();
    chk("t4_gnt1", 32'(bus.gnt1), 32'h1);
    exp_q.push_back(32'hCAFE_0012);
    bus.req1 = 0;
    tick();
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 10'd20; bus.wdata0 = 32'h77;
    tick();
    chk("t4_no_gnt_resp", 32'(bus.gnt0), 32'h0);
    chk("t4_rvalid1", 32'(bus.rvalid1), 32'h1);
    chk("t4_rdata", bus.rdata, pop_exp());
    tick();
    chk("t4_no_gnt_idle", 32'(bus.gnt0), 32'h0);
    tick();
    chk("t4_gnt0", 32'(bus.gnt0), 32'h1);
    chk("t4_address", 32'(bus.address), 32'd20);
    chk("t4_data_out", bus.data_out, 32'h77);
    bus.req0 = 0;
    tick();

    // contention from reset: grants alternate 1,0,1,0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 10'd1; bus.wdata0 = 32'h1;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 10'd2; bus.wdata1 = 32'h2;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("t3_gnt1_c%0d", i), 32'(bus.gnt1), 32'((i % 4) == 1));
      chk($sformatf("t3_gnt0_c%0d", i), 32'(bus.gnt0), 32'((i % 4) == 3));
      chk($sformatf("t3_excl_c%0d", i), 32'(bus.gnt0 & bus.gnt1), 32'h0);
      if (bus.gnt1) chk($sformatf("t3_addr1_c%0d", i), 32'(bus.address), 32'd2);
      if (bus.gnt0) chk($sformatf("t3_addr0_c%0d", i), 32'(bus.address), 32'd1);
    end
    bus.req0 = 0; bus.req1 = 0;
    tick();
    chk_quiet("t3_after");

    // reset in the middle of a read
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 10'd12;
    tick();
    chk("t5_gnt0", 32'(bus.gnt0), 32'h1);
    bus.req0 = 0;
    tick();
    chk("t5_wait", 32'(state_dbg), 32'(WAIT));
    rst = 1'b1;
    tick();
    chk_quiet("t5_rst_strobes");
    chk("t5_rst_address", 32'(bus.address), 32'h0);
    chk("t5_rst_rdata", bus.rdata, 32'h0);
    chk("t5_rst_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      rv_seen += int'(bus.rvalid0 | bus.rvalid1);
    end
    chk("t5_no_rvalid", 32'(rv_seen), 32'h0);
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 10'd3; bus.wdata1 = 32'h55;
    tick();
    chk("t5_gnt1", 32'(bus.gnt1), 32'h1);
    chk("t5_write", 32'(bus.write), 32'h1);
    chk("t5_address", 32'(bus.address), 32'd3);
    bus.req1 = 0;
    tick();

`ifdef DMEM_ARB_STATS_EN
    // three more grants to port 0 after the single port-1 grant since reset
    for (int k = 0; k < 3; k++) begin
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = AB'(k); bus.wdata0 = 32'(k);
      tick();
      chk($sformatf("t6_gnt0_%0d", k), 32'(bus.gnt0), 32'h1);
      bus.req0 = 0;
      tick();
    end
    chk("t6_gcnt0", 32'(gcnt0), 32'd3);
    chk("t6_gcnt1", 32'(gcnt1), 32'd1);
`endif

    chk("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
